// File: rtl/udp_tx_pkg.sv
// Shared types and protocol constants for the byte-serial UDP frame generator.
package udp_tx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCsum,
    StEth,
    StIp,
    StUdp,
    StPay
  } state_e;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
  localparam logic [7:0]  IP_VER_IHL     = 8'h45;

  localparam int unsigned ETH_HDR_BYTES = 14;
  localparam int unsigned IP_HDR_BYTES  = 20;
  localparam int unsigned UDP_HDR_BYTES = 8;

endpackage

// File: rtl/ipv4_hdr_csum.sv
// Combinational IPv4 header checksum; flags/fragment and checksum words are zero.
module ipv4_hdr_csum
  import udp_tx_pkg::*;
(
  input  logic [15:0] i_total_len,
  input  logic [15:0] i_ident,
  input  logic [7:0]  i_ttl,
  input  logic [7:0]  i_proto,
  input  logic [31:0] i_src_ip,
  input  logic [31:0] i_dst_ip,
  output logic [15:0] o_csum
);

  logic [19:0] w_sum;
  logic [16:0] w_fold1;
  logic [15:0] w_fold2;

  assign w_sum = 20'({IP_VER_IHL, 8'h00}) + 20'(i_total_len) + 20'(i_ident)
               + 20'({i_ttl, i_proto})
               + 20'(i_src_ip[31:16]) + 20'(i_src_ip[15:0])
               + 20'(i_dst_ip[31:16]) + 20'(i_dst_ip[15:0]);

  // Two folds: the first can itself carry out of bit 15.
  assign w_fold1 = {1'b0, w_sum[15:0]} + {13'b0, w_sum[19:16]};
  assign w_fold2 = w_fold1[15:0] + {15'b0, w_fold1[16]};
  assign o_csum  = ~w_fold2;

endmodule

// File: rtl/udp_packet_tx.sv
// Ethernet/IPv4/UDP frame generator: latches a message on START and streams the
// whole frame one byte per handshake.
module udp_packet_tx
  import udp_tx_pkg::*;
#(
  parameter int unsigned MSG_BYTES = 2,
  parameter logic [7:0]  TTL       = 8'h40,
  parameter logic [15:0] SRC_PORT  = 16'd5000,
  parameter logic [15:0] DST_PORT  = 16'd5001
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic [31:0]            LOCAL_IP,
  input  logic [47:0]            LOCAL_MAC,
  input  logic [31:0]            DST_IP,
  input  logic [47:0]            DST_MAC,
  input  logic [8*MSG_BYTES-1:0] MSG,
  input  logic                   START,
  output logic                   READY_FOR_SEND,
  output logic [7:0]             M_TDATA,
  output logic                   M_TVALID,
  input  logic                   M_TREADY,
  output logic                   M_TFIRST,
  output logic                   M_TLAST
);

  localparam logic [15:0] TOTAL_LEN = 16'(IP_HDR_BYTES + UDP_HDR_BYTES + MSG_BYTES);
  localparam logic [15:0] UDP_LEN   = 16'(UDP_HDR_BYTES + MSG_BYTES);
  localparam logic [6:0]  ETH_LAST  = 7'(ETH_HDR_BYTES - 1);
  localparam logic [6:0]  IP_LAST   = 7'(IP_HDR_BYTES - 1);
  localparam logic [6:0]  UDP_LAST  = 7'(UDP_HDR_BYTES - 1);
  localparam logic [6:0]  PAY_LAST  = 7'(MSG_BYTES - 1);

  state_e                 r_state, w_state_d;
  logic [6:0]             r_idx, w_idx_d;
  logic [31:0]            r_local_ip, r_dst_ip;
  logic [47:0]            r_local_mac, r_dst_mac;
  logic [8*MSG_BYTES-1:0] r_msg;
  logic [15:0]            r_id_cnt, r_pkt_id, r_csum;
  logic [15:0]            w_csum;
  logic                   w_valid, w_hs, w_pay_done;
  logic [111:0]           w_eth;
  logic [159:0]           w_ip;
  logic [63:0]            w_udp;

  ipv4_hdr_csum u_csum (
    .i_total_len(TOTAL_LEN),
    .i_ident    (r_pkt_id),
    .i_ttl      (TTL),
    .i_proto    (IP_PROTO_UDP),
    .i_src_ip   (r_local_ip),
    .i_dst_ip   (r_dst_ip),
    .o_csum     (w_csum)
  );

  assign w_eth = {r_dst_mac, r_local_mac, ETHERTYPE_IPV4};
  assign w_ip  = {IP_VER_IHL, 8'h00, TOTAL_LEN, r_pkt_id, 16'h0000, TTL, IP_PROTO_UDP,
                  r_csum, r_local_ip, r_dst_ip};
  assign w_udp = {SRC_PORT, DST_PORT, UDP_LEN, 16'h0000};

  assign w_valid        = (r_state == StEth) || (r_state == StIp) ||
                          (r_state == StUdp) || (r_state == StPay);
  assign w_hs           = w_valid && M_TREADY;
  assign w_pay_done     = (r_state == StPay) && w_hs && (r_idx == PAY_LAST);
  assign M_TVALID       = w_valid;
  assign READY_FOR_SEND = (r_state == StIdle);

  always_comb begin
    w_state_d = r_state;
    M_TDATA   = 8'h00;
    M_TFIRST  = 1'b0;
    M_TLAST   = 1'b0;
    unique case (r_state)
      StIdle: if (START) w_state_d = StCsum;
      StCsum: w_state_d = StEth;
      StEth: begin
        for (int i = 0; i < 14; i++) if (r_idx == 7'(i)) M_TDATA = w_eth[8*(13-i) +: 8];
        M_TFIRST = (r_idx == 7'd0);
        if (w_hs && r_idx == ETH_LAST) w_state_d = StIp;
      end
      StIp: begin
        for (int i = 0; i < 20; i++) if (r_idx == 7'(i)) M_TDATA = w_ip[8*(19-i) +: 8];
        if (w_hs && r_idx == IP_LAST) w_state_d = StUdp;
      end
      StUdp: begin
        for (int i = 0; i < 8; i++) if (r_idx == 7'(i)) M_TDATA = w_udp[8*(7-i) +: 8];
        if (w_hs && r_idx == UDP_LAST) w_state_d = StPay;
      end
      StPay: begin
        for (int i = 0; i < int'(MSG_BYTES); i++) begin
          if (r_idx == 7'(i)) M_TDATA = r_msg[8*(int'(MSG_BYTES)-1-i) +: 8];
        end
        M_TLAST = (r_idx == PAY_LAST);
        if (w_pay_done) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase

    w_idx_d = r_idx;
    if (w_state_d != r_state) w_idx_d = 7'd0;
    else if (w_hs)            w_idx_d = r_idx + 7'd1;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state  <= StIdle;
      r_idx    <= 7'd0;
      r_id_cnt <= 16'h0000;
    end else begin
      r_state <= w_state_d;
      r_idx   <= w_idx_d;
      if (w_pay_done) r_id_cnt <= r_id_cnt + 16'd1;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_local_ip  <= '0;
      r_dst_ip    <= '0;
      r_local_mac <= '0;
      r_dst_mac   <= '0;
      r_msg       <= '0;
      r_pkt_id    <= '0;
      r_csum      <= '0;
    end else begin
      if (r_state == StIdle && START) begin
        r_local_ip  <= LOCAL_IP;
        r_dst_ip    <= DST_IP;
        r_local_mac <= LOCAL_MAC;
        r_dst_mac   <= DST_MAC;
        r_msg       <= MSG;
        r_pkt_id    <= r_id_cnt;
      end
      if (r_state == StCsum) r_csum <= w_csum;
    end
  end

endmodule
